// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU control / multiply-divide block.
//   - ALU opcodes driven to the execute-stage ALU
//   - operation-class select codes (i_operation)
//   - funct codes for multi-cycle ops and HI/LO moves
//   - multiply/divide FSM state encoding
package alu_pkg;

  // ALU opcodes (the ALU's own encoding, not the MIPS funct numbering).
  localparam logic [3:0] ALU_SLL  = 4'b0000;
  localparam logic [3:0] ALU_SLLV = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_SRLV = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SRAV = 4'b1010;
  localparam logic [3:0] ALU_SUB  = 4'b1011;
  localparam logic [3:0] ALU_ADD  = 4'b1100;

  // Operation classes.
  localparam logic [1:0] OPSEL_RTYPE  = 2'b00;
  localparam logic [1:0] OPSEL_MEM    = 2'b01;
  localparam logic [1:0] OPSEL_BRANCH = 2'b10;
  localparam logic [1:0] OPSEL_SLTI   = 2'b11;

  // funct codes handled by this block.
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_md_funct(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative unsigned multiply / restoring divide datapath.
// Operates on magnitudes only; sign handling lives in the controller.
//   i_clock, i_reset_n : clock, async active-low reset
//   i_load             : capture operands, clear accumulator and step counter
//   i_step             : perform one shift-add / shift-subtract step
//   i_is_div           : 1 = divide step, 0 = multiply step
//   i_a_mag, i_b_mag   : multiplier/dividend and multiplicand/divisor magnitudes
//   o_last_step        : high during the step that completes NB_DATA steps
//   o_acc_hi, o_acc_lo : mult: product upper/lower; div: remainder/quotient
module md_iter_unit #(
  parameter int NB_DATA = 32
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic [NB_DATA-1:0] i_a_mag,
  input  logic [NB_DATA-1:0] i_b_mag,
  output logic               o_last_step,
  output logic [NB_DATA-1:0] o_acc_hi,
  output logic [NB_DATA-1:0] o_acc_lo
);

  localparam int CW = $clog2(NB_DATA) + 1;

  logic [NB_DATA-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
  logic [CW-1:0]      cnt_q;
  logic [NB_DATA:0]   mul_sum;
  logic [NB_DATA:0]   div_shift;
  logic [NB_DATA-1:0] div_sub;
  logic               div_ge;

  // Multiply: {hi,lo} holds {partial product, remaining multiplier bits};
  // add the multiplicand when the multiplier LSB is set, then shift right.
  // Divide: {hi,lo} holds {partial remainder, remaining dividend bits};
  // shift left, subtract the divisor if it fits, shift the quotient bit in.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[NB_DATA-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    // When the subtraction succeeds the difference is below the divisor,
    // so the low NB_DATA bits carry the whole result.
    div_sub   = div_shift[NB_DATA-1:0] - b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (i_is_div) begin
      if (div_ge) begin
        hi_d = div_sub;
        lo_d = {lo_q[NB_DATA-2:0], 1'b1};
      end else begin
        hi_d = div_shift[NB_DATA-1:0];
        lo_d = {lo_q[NB_DATA-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[NB_DATA:1];
      lo_d = {mul_sum[0], lo_q[NB_DATA-1:1]};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (i_load) begin
      hi_q  <= '0;
      lo_q  <= i_a_mag;
      b_q   <= i_b_mag;
      cnt_q <= '0;
    end else if (i_step) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_last_step = i_step && (cnt_q == CW'(NB_DATA - 1));
  assign o_acc_hi    = hi_q;
  assign o_acc_lo    = lo_q;

endmodule

// File: rtl/alu_md_ctrl.sv
// alu_md_ctrl: execute-stage ALU decode plus multi-cycle MULT/DIV sequencer
// with architectural HI/LO registers.
//   i_clock, i_reset_n       : clock, async active-low reset
//   i_valid, i_flush         : instruction valid / squash (also aborts MULT/DIV)
//   i_operation              : class 00 R-type, 01 load/store, 10 branch, 11 SLTI
//   i_ctrl_opcode            : funct field
//   i_rs_data, i_rt_data     : operands
//   o_alu_opcode             : ALU opcode (combinational, reset-independent)
//   o_second_ope_sa          : ALU second operand is shamt
//   o_first_ope_rt           : ALU first operand is rt
//   o_stall                  : freeze IF/ID/EX while MULT/DIV runs
//   o_hilo_data              : HI for MFHI, else LO
//   o_hi, o_lo               : architectural HI/LO
//   o_md_done, o_div_by_zero : one-cycle pulses when HI/LO were just written
// Handshake: an instruction is accepted on a rising edge when i_valid is high
// and i_flush is low; a MULT/DIV then holds o_stall high until the DONE cycle,
// in which the held instruction retires without restarting.
module alu_md_ctrl
  import alu_pkg::*;
#(
  parameter int NB_DATA        = 32,
  parameter int NB_CTRL_OPCODE = 6,
  parameter int NB_ALU_OPCODE  = 4,
  parameter int NB_ALU_OP_SEL  = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_valid,
  input  logic                      i_flush,
  input  logic [NB_ALU_OP_SEL-1:0]  i_operation,
  input  logic [NB_CTRL_OPCODE-1:0] i_ctrl_opcode,
  input  logic [NB_DATA-1:0]        i_rs_data,
  input  logic [NB_DATA-1:0]        i_rt_data,
  output logic [NB_ALU_OPCODE-1:0]  o_alu_opcode,
  output logic                      o_second_ope_sa,
  output logic                      o_first_ope_rt,
  output logic                      o_stall,
  output logic [NB_DATA-1:0]        o_hilo_data,
  output logic [NB_DATA-1:0]        o_hi,
  output logic [NB_DATA-1:0]        o_lo,
  output logic                      o_md_done,
  output logic                      o_div_by_zero
);

  md_state_e          state_q, state_d;
  logic [3:0]         alu_op;
  logic               is_rtype, start, load, step, last_step, hilo_wr, stall;
  logic               mt_ok, op_signed, op_div, a_neg, b_neg;
  logic [NB_DATA-1:0] a_mag, b_mag, acc_hi, acc_lo;
  logic               neg_res_q, neg_rem_q, is_div_q, dz_q;
  logic [NB_DATA-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [2*NB_DATA-1:0] prod_fix;
  logic [NB_DATA-1:0] quo_fix, rem_fix, res_hi, res_lo;

  // ---------------- ALU decode (pure combinational) ----------------
  always_comb begin
    alu_op = ALU_ADD;
    case (i_operation)
      OPSEL_RTYPE:  alu_op = i_ctrl_opcode[3:0];
      OPSEL_MEM:    alu_op = ALU_ADD;
      OPSEL_BRANCH: alu_op = ALU_SUB;
      default:      alu_op = ALU_SLT;
    endcase
  end

  assign o_alu_opcode    = NB_ALU_OPCODE'(alu_op);
  assign o_second_ope_sa = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
  assign o_first_ope_rt  = (alu_op == ALU_SRAV) || (alu_op == ALU_SRLV) || (alu_op == ALU_SLLV);

  // ---------------- operand preparation ----------------
  assign is_rtype  = (i_operation == OPSEL_RTYPE);
  assign start     = i_valid && !i_flush && is_rtype && is_md_funct(i_ctrl_opcode);
  assign op_signed = (i_ctrl_opcode == FUNCT_MULT) || (i_ctrl_opcode == FUNCT_DIV);
  assign op_div    = (i_ctrl_opcode == FUNCT_DIV)  || (i_ctrl_opcode == FUNCT_DIVU);
  assign a_neg     = op_signed && i_rs_data[NB_DATA-1];
  assign b_neg     = op_signed && i_rt_data[NB_DATA-1];
  assign a_mag     = a_neg ? -i_rs_data : i_rs_data;
  assign b_mag     = b_neg ? -i_rt_data : i_rt_data;

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    hilo_wr = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          stall   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (i_flush) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (last_step) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        stall = 1'b1;
        if (i_flush) begin
          state_d = ST_IDLE;
        end else begin
          hilo_wr = 1'b1;
          state_d = ST_DONE;
        end
      end
      // The held instruction retires here; start is deliberately ignored.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_stall       = stall;
  assign o_md_done     = (state_q == ST_DONE);
  assign o_div_by_zero = (state_q == ST_DONE) && dz_q;

  // Sign/op-type context captured at start, used by the FIX step.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
    end else if (load) begin
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      is_div_q  <= op_div;
      dz_q      <= op_div && (i_rt_data == '0);
    end
  end

  md_iter_unit #(.NB_DATA(NB_DATA)) u_iter (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_load      (load),
    .i_step      (step),
    .i_is_div    (is_div_q),
    .i_a_mag     (a_mag),
    .i_b_mag     (b_mag),
    .o_last_step (last_step),
    .o_acc_hi    (acc_hi),
    .o_acc_lo    (acc_lo)
  );

  // ---------------- sign fix-up ----------------
  // A zero divisor leaves |dividend| in the remainder and all ones in the
  // quotient; restoring the dividend sign gives HI = dividend, and LO is
  // forced to all ones regardless of operand signs.
  always_comb begin
    prod_fix = neg_res_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix  = neg_res_q ? -acc_lo : acc_lo;
    rem_fix  = neg_rem_q ? -acc_hi : acc_hi;
    if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = dz_q ? '1 : quo_fix;
    end else begin
      res_hi = prod_fix[2*NB_DATA-1:NB_DATA];
      res_lo = prod_fix[NB_DATA-1:0];
    end
  end

  // ---------------- HI/LO registers ----------------
  assign mt_ok = (state_q == ST_IDLE) && i_valid && !i_flush && !start && is_rtype;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_wr) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (mt_ok && (i_ctrl_opcode == FUNCT_MTHI)) begin
      hi_d = i_rs_data;
    end else if (mt_ok && (i_ctrl_opcode == FUNCT_MTLO)) begin
      lo_d = i_rs_data;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign o_hi        = hi_q;
  assign o_lo        = lo_q;
  assign o_hilo_data = (i_ctrl_opcode == FUNCT_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_alu_md_ctrl.sv
// tb_alu_md_ctrl: self-checking bench for alu_md_ctrl. Expected HI/LO come
// from plain 64-bit arithmetic on the operands; decode expectations from the
// opcode tables.
module tb_alu_md_ctrl;

  localparam int N = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // ---------------- clock / reset / DUT ----------------
  logic          i_clock = 1'b0;
  logic          i_reset_n;
  logic          i_valid, i_flush;
  logic [1:0]    i_operation;
  logic [5:0]    i_ctrl_opcode;
  logic [N-1:0]  i_rs_data, i_rt_data;
  logic [3:0]    o_alu_opcode;
  logic          o_second_ope_sa, o_first_ope_rt, o_stall;
  logic [N-1:0]  o_hilo_data, o_hi, o_lo;
  logic          o_md_done, o_div_by_zero;

  always #5 i_clock = ~i_clock;

  alu_md_ctrl dut (
    .i_clock         (i_clock),
    .i_reset_n       (i_reset_n),
    .i_valid         (i_valid),
    .i_flush         (i_flush),
    .i_operation     (i_operation),
    .i_ctrl_opcode   (i_ctrl_opcode),
    .i_rs_data       (i_rs_data),
    .i_rt_data       (i_rt_data),
    .o_alu_opcode    (o_alu_opcode),
    .o_second_ope_sa (o_second_ope_sa),
    .o_first_ope_rt  (o_first_ope_rt),
    .o_stall         (o_stall),
    .o_hilo_data     (o_hilo_data),
    .o_hi            (o_hi),
    .o_lo            (o_lo),
    .o_md_done       (o_md_done),
    .o_div_by_zero   (o_div_by_zero)
  );

  // ---------------- scoreboard state ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [N-1:0] m_hi, m_lo;
  logic [2*N-1:0] exp_q[$];

  // ---------------- reference models ----------------
  function automatic logic [3:0] model_alu(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b00:   return f[3:0];
      2'b01:   return 4'b1100;
      2'b10:   return 4'b1011;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic void model_md(input logic [5:0] f, input logic [N-1:0] a,
                                   input logic [N-1:0] b, output logic dz);
    longint sa, sb, qq, rr;
    logic [2*N-1:0] p;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (f == F_MULT) begin
      p = sa * sb;
      m_hi = p[2*N-1:N];
      m_lo = p[N-1:0];
    end else if (f == F_MULTU) begin
      p = {32'h0, a} * {32'h0, b};
      m_hi = p[2*N-1:N];
      m_lo = p[N-1:0];
    end else if (b == '0) begin
      dz = 1'b1;
      m_hi = a;
      m_lo = '1;
    end else if (f == F_DIV) begin
      qq = sa / sb;
      rr = sa % sb;
      m_lo = qq[N-1:0];
      m_hi = rr[N-1:0];
    end else begin
      m_lo = a / b;
      m_hi = a % b;
    end
    exp_q.push_back({m_hi, m_lo});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic fl, input logic [1:0] op,
                       input logic [5:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    i_valid = v; i_flush = fl; i_operation = op; i_ctrl_opcode = f;
    i_rs_data = a; i_rt_data = b;
  endtask

  // Runs one MULT/DIV to its DONE cycle and checks latency, hold, result,
  // pulses; optionally flushes during DONE, then checks the following cycle.
  task automatic run_md(input logic [5:0] f, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic flush_in_done, input string nm);
    logic [2*N-1:0] exp;
    logic [N-1:0]   old_lo;
    logic           exp_dz, mid_bad;
    int             n;
    old_lo = m_lo;
    model_md(f, a, b, exp_dz);
    exp = exp_q.pop_front();
    @(negedge i_clock);
    drive(1'b1, 1'b0, 2'b00, f, a, b);
    #1;
    n = 0;
    mid_bad = 1'b0;
    while (o_stall === 1'b1 && n < 100) begin
      if (o_lo !== old_lo || o_hilo_data !== old_lo || o_md_done !== 1'b0) mid_bad = 1'b1;
      n++;
      @(negedge i_clock); #1;
    end
    n_vec++; if (n !== N + 2) begin n_err++; $display("FAIL %s stall_cycles: got %0d want %0d", nm, n, N + 2); end
    n_vec++; if (mid_bad) begin n_err++; $display("FAIL %s lo_hold_during_stall: lo changed early, want %h", nm, old_lo); end
    n_vec++; if ({o_hi, o_lo} !== exp) begin n_err++; $display("FAIL %s hilo: got %h_%h want %h_%h", nm, o_hi, o_lo, exp[2*N-1:N], exp[N-1:0]); end
    n_vec++; if (o_md_done !== 1'b1) begin n_err++; $display("FAIL %s md_done: got %b want 1", nm, o_md_done); end
    n_vec++; if (o_div_by_zero !== exp_dz) begin n_err++; $display("FAIL %s div_by_zero: got %b want %b", nm, o_div_by_zero, exp_dz); end
    n_vec++; if (o_hilo_data !== exp[N-1:0]) begin n_err++; $display("FAIL %s held_mflo: got %h want %h", nm, o_hilo_data, exp[N-1:0]); end
    if (flush_in_done) i_flush = 1'b1;
    // Inputs still hold the instruction across the DONE edge: no restart allowed.
    @(negedge i_clock);
    drive(1'b0, 1'b0, 2'b00, F_MFLO, '0, '0);
    #1;
    n_vec++; if (o_md_done !== 1'b0 || o_div_by_zero !== 1'b0) begin n_err++; $display("FAIL %s pulse_len: done=%b dz=%b want 0 0", nm, o_md_done, o_div_by_zero); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL %s after_done_stall: got %b want 0", nm, o_stall); end
    n_vec++; if ({o_hi, o_lo} !== exp) begin n_err++; $display("FAIL %s hilo_retained: got %h_%h want %h_%h", nm, o_hi, o_lo, exp[2*N-1:N], exp[N-1:0]); end
  endtask

  task automatic mt(input logic [5:0] f, input logic [N-1:0] v, input logic fl);
    @(negedge i_clock);
    drive(1'b1, fl, 2'b00, f, v, $urandom);
    if (!fl) begin
      if (f == F_MTHI) m_hi = v;
      else             m_lo = v;
    end
  endtask

  task automatic mf_check(input logic [5:0] f, input string nm);
    logic [N-1:0] exp;
    @(negedge i_clock);
    drive(1'b1, 1'b0, 2'b00, f, $urandom, $urandom);
    #1;
    exp = (f == F_MFHI) ? m_hi : m_lo;
    n_vec++; if (o_hilo_data !== exp) begin n_err++; $display("FAIL %s hilo_data: got %h want %h", nm, o_hilo_data, exp); end
    n_vec++; if (o_hi !== m_hi || o_lo !== m_lo) begin n_err++; $display("FAIL %s regs: got %h_%h want %h_%h", nm, o_hi, o_lo, m_hi, m_lo); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    i_reset_n = 1'b0;
    drive(1'b0, 1'b0, 2'b01, 6'b101010, '0, '0);
    repeat (2) @(negedge i_clock);
    #1;
    n_vec++; if (o_hi !== '0 || o_lo !== '0) begin n_err++; $display("FAIL reset_hilo: got %h_%h want 0_0", o_hi, o_lo); end
    n_vec++; if (o_stall !== 1'b0 || o_md_done !== 1'b0 || o_div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_flags: stall=%b done=%b dz=%b want 0 0 0", o_stall, o_md_done, o_div_by_zero); end
    n_vec++; if (o_alu_opcode !== 4'b1100) begin n_err++; $display("FAIL reset_decode: got %b want 1100", o_alu_opcode); end
    @(negedge i_clock);
    i_reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_decode;
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] e;
    for (int i = 0; i < 42; i++) begin
      if (i == 0)      begin op = 2'b01; f = 6'($urandom); end
      else if (i == 1) begin op = 2'b00; f = 6'b000000; end
      else             begin op = 2'($urandom_range(0, 3)); f = 6'($urandom); end
      @(negedge i_clock);
      drive(1'b0, 1'($urandom_range(0, 1)), op, f, $urandom, $urandom);
      #1;
      e = model_alu(op, f);
      n_vec++; if (o_alu_opcode !== e) begin n_err++; $display("FAIL decode_op op=%b f=%b: got %b want %b", op, f, o_alu_opcode, e); end
      n_vec++; if (o_second_ope_sa !== (e inside {4'b0000, 4'b0010, 4'b0011})) begin n_err++; $display("FAIL decode_sa alu=%b: got %b", e, o_second_ope_sa); end
      n_vec++; if (o_first_ope_rt !== (e inside {4'b1010, 4'b0110, 4'b0001})) begin n_err++; $display("FAIL decode_rt alu=%b: got %b", e, o_first_ope_rt); end
      n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL decode_stall: got %b want 0", o_stall); end
    end
  endtask

  task automatic test_md_directed;
    run_md(F_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg3x5");
    run_md(F_DIVU, 32'd100, 32'd7, 1'b0, "divu_100_7");
    run_md(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    run_md(F_DIV, 32'd5, 32'd0, 1'b0, "div_5_0");
    run_md(F_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, "div_m5_0");
    run_md(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    run_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_m1");
  endtask

  task automatic test_hilo_moves;
    mt(F_MTLO, 32'h0000_1234, 1'b0);
    mf_check(F_MFLO, "mtlo_mflo");
    mt(F_MTHI, $urandom, 1'b0);
    mf_check(F_MFHI, "mthi_mfhi");
    mf_check(F_MFLO, "mthi_keeps_lo");
    mt(F_MTHI, $urandom, 1'b1);
    mf_check(F_MFHI, "mthi_flushed");
    mt(F_MTLO, $urandom | 32'h1, 1'b0);
    mf_check(F_MFLO, "mtlo_again");
  endtask

  task automatic test_reset_mid_op;
    @(negedge i_clock);
    drive(1'b1, 1'b0, 2'b00, F_MULT, $urandom, $urandom);
    repeat (6) @(negedge i_clock);
    #2;
    i_reset_n = 1'b0;
    i_valid = 1'b0;
    #1;
    n_vec++; if (o_hi !== '0 || o_lo !== '0) begin n_err++; $display("FAIL reset_mid_hilo: got %h_%h want 0_0", o_hi, o_lo); end
    n_vec++; if (o_stall !== 1'b0 || o_md_done !== 1'b0) begin n_err++; $display("FAIL reset_mid_flags: stall=%b done=%b want 0 0", o_stall, o_md_done); end
    @(negedge i_clock);
    i_reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(negedge i_clock);
    #1;
    n_vec++; if (o_stall !== 1'b0 || o_hi !== '0 || o_lo !== '0) begin n_err++; $display("FAIL reset_mid_after: stall=%b hilo=%h_%h want 0 0_0", o_stall, o_hi, o_lo); end
  endtask

  task automatic test_random_md;
    logic [5:0]   f;
    logic [N-1:0] a, b;
    for (int i = 0; i < 14; i++) begin
      f = F_MULT | 6'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = N'($urandom_range(1, 20));
        2: b = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        default: b = '0;
      endcase
      run_md(f, a, b, 1'($urandom_range(0, 1)), "random_md");
      if (i % 4 == 3) mf_check(F_MFHI, "random_mfhi");
    end
  endtask

  task automatic test_flush(input int flush_cycle, input logic [5:0] f, input string nm);
    logic [N-1:0] hi0, lo0;
    logic         done_seen;
    hi0 = m_hi;
    lo0 = m_lo;
    @(negedge i_clock);
    drive(1'b1, 1'b0, 2'b00, f, $urandom, $urandom_range(1, 1000));
    for (int i = 0; i < flush_cycle; i++) @(negedge i_clock);
    i_flush = 1'b1;
    #1;
    n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL %s stall_before: got %b want 1", nm, o_stall); end
    @(negedge i_clock); #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL %s stall_drop: got %b want 0", nm, o_stall); end
    drive(1'b0, 1'b0, 2'b00, F_MFLO, '0, '0);
    done_seen = 1'b0;
    for (int i = 0; i < N + 6; i++) begin
      @(negedge i_clock); #1;
      if (o_md_done !== 1'b0) done_seen = 1'b1;
    end
    n_vec++; if (done_seen) begin n_err++; $display("FAIL %s no_done: got pulse want none", nm); end
    n_vec++; if (o_hi !== hi0 || o_lo !== lo0) begin n_err++; $display("FAIL %s hilo_kept: got %h_%h want %h_%h", nm, o_hi, o_lo, hi0, lo0); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_reset_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, '0, '0, '0);
    test_reset();
    test_decode();
    test_md_directed();
    test_hilo_moves();
    test_reset_mid_op();
    test_hilo_moves();
    test_random_md();
    test_flush(10, F_MULT, "flush_busy10");
    test_flush(N + 1, F_DIV, "flush_fix");
    test_flush(1, F_DIVU, "flush_busy1");
    run_md(F_MULT, $urandom, $urandom, 1'b1, "flush_in_done");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_md_ctrl.md
ALU_MD_CTRL -- requirements
Module: alu_md_ctrl

Interface
REQ-001 Parameter NB_DATA, 32, operand/HI/LO width; SHALL be even and >= 8.
REQ-002 Parameter NB_CTRL_OPCODE, 6, width of funct field.
REQ-003 Parameter NB_ALU_OPCODE, 4, ALU opcode width.
REQ-004 Parameter NB_ALU_OP_SEL, 2, operation-class select width.
REQ-005 Ports SHALL be, in order:
- i_clock  in  1  single clock; all state on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  ID/EX holds a valid instruction.
- i_flush  in  1  squash current instruction / abort multi-cycle op.
- i_operation  in  NB_ALU_OP_SEL  class: 00 R-type, 01 load/store, 10 branch, 11 set-less-than immediate.
- i_ctrl_opcode  in  NB_CTRL_OPCODE  funct field.
- i_rs_data, i_rt_data  in  NB_DATA each  operands.
- o_alu_opcode  out  NB_ALU_OPCODE  ALU opcode.
- o_second_ope_sa  out  1  ALU second operand is shamt.
- o_first_ope_rt  out  1  ALU first operand is rt (variable shifts).
- o_stall  out  1  freeze IF/ID/EX.
- o_hilo_data  out  NB_DATA  HI (MFHI) or LO (MFLO) read value.
- o_hi, o_lo  out  NB_DATA each  architectural HI/LO.
- o_md_done  out  1  one-cycle pulse: HI/LO just written by MULT/DIV.
- o_div_by_zero  out  1  one-cycle pulse with o_md_done for a zero divisor.

Function
REQ-006 Decode SHALL be combinational: 00 -> i_ctrl_opcode[3:0]; 01 -> 1100 (ADD); 10 -> 1011 (SUB); 11 -> 1001 (SLT).
REQ-007 o_second_ope_sa SHALL be 1 iff o_alu_opcode in {0000,0010,0011}; o_first_ope_rt 1 iff in {1010,0110,0001}.
REQ-008 Multi-cycle funct (class 00 only): MULT 011000, MULTU 011001, DIV 011010, DIVU 011011; HI/LO moves: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
REQ-009 FSM states IDLE, BUSY, FIX, DONE; reset state IDLE.
REQ-010 IDLE: start = i_valid & multi-cycle funct & !i_flush; on start latch operand magnitudes, result signs, op type; counter=0; go BUSY.
REQ-011 o_stall SHALL be 1 in IDLE when start is true, in BUSY, and in FIX; 0 in DONE and otherwise.
REQ-012 BUSY: one shift-add (mult) or restoring shift-subtract (div) step per cycle; after NB_DATA steps go FIX.
REQ-013 FIX: signed ops negate product if signs differ; quotient negated if signs differ, remainder takes dividend sign; write HI/LO (mult: HI=upper, LO=lower product; div: HI=remainder, LO=quotient); go DONE.
REQ-014 Total stall = NB_DATA+2 cycles (34 at default); new HI/LO visible first cycle in DONE.
REQ-015 DONE: pulse o_md_done; no start this cycle (held instruction retires); go IDLE.
REQ-016 Zero divisor: same latency; HI=dividend, LO=all ones; o_div_by_zero pulses with o_md_done.
REQ-017 i_flush in BUSY or FIX: abort to IDLE next cycle, HI/LO unchanged, no done pulse; flush in DONE has no effect.
REQ-018 MTHI/MTLO: write i_rs_data to HI/LO at edge when i_valid & !i_flush & state IDLE & !start.
REQ-019 o_hilo_data SHALL be o_hi when funct=MFHI else o_lo, combinational from registered HI/LO.

Reset
REQ-020 Reset assertion asynchronously forces IDLE, counter 0, HI/LO 0, o_md_done/o_div_by_zero/o_stall 0, aborting any op.
REQ-021 Combinational decode outputs SHALL be unaffected by reset.

Structure
REQ-022 Package alu_pkg SHALL hold ALU opcodes, funct codes, FSM state encoding.
REQ-023 Iterative datapath (accumulator, shift registers, step counter) SHALL be sub-module md_iter_unit; FSM and decode stay in alu_md_ctrl.

Verification
REQ-024 i_operation=01, funct any -> o_alu_opcode=1100, sa=0, rt=0; funct 000000 class 00 -> 0000, sa=1.
REQ-025 MULT rs=0xFFFFFFFD (-3), rt=5 -> o_stall high 34 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1, o_md_done pulse.
REQ-026 DIVU 100/7 -> LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-027 DIV 5/0 -> HI=5, LO=0xFFFFFFFF, o_div_by_zero and o_md_done coincident.
REQ-028 MULT started, i_flush at BUSY cycle 10 -> IDLE next cycle, stall drops, HI/LO keep prior values; i_reset_n low mid-op -> HI/LO=0 immediately.
REQ-029 MTLO 0x1234 then MFLO -> o_hilo_data=0x1234; MULT followed by held MFLO reads new LO only after DONE.
